// File: rtl/prog_loader_pkg.sv
// Shared parameters and state encoding for the boot-time program loader.
package prog_loader_pkg;

  localparam int LOADER_WORD    = 32;
  localparam int LOADER_ADDR_W  = 8;
  localparam int LOADER_TIMEOUT = 1024;
  localparam int BYTE_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles a little-endian word from a byte stream; byte k lands in word[8k+7:8k].
module byte_packer import prog_loader_pkg::*; #(
  parameter int WORD = LOADER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD-1:0]   word_next,
  output logic              full
);

  localparam int BYTES = WORD / BYTE_W;
  localparam int CW    = $clog2(BYTES + 1);

  logic [WORD-1:0] word_r;
  logic [CW-1:0]   cnt_r;

  // Shifting right and inserting at the top leaves the first byte in the low lane.
  assign word_next = (word_r >> BYTE_W) | (WORD'(data) << (WORD - BYTE_W));
  // full marks the push that completes the word, so word_next is the whole word then.
  assign full      = push && (cnt_r == CW'(BYTES - 1));

  // Byte shift register and byte counter.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      word_r <= '0;
      cnt_r  <= '0;
    end else if (push) begin
      word_r <= word_next;
      cnt_r  <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a byte stream, packs words and writes them to memory
// while holding the core stalled.
module prog_loader import prog_loader_pkg::*; #(
  parameter int WORD    = LOADER_WORD,
  parameter int ADDR_W  = LOADER_ADDR_W,
  parameter int TIMEOUT = LOADER_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD-1:0]   mem_in,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t   state_r, next_s;
  logic [ADDR_W:0] len_r, addr_r;
  logic [TW-1:0]   tmo_r;
  logic            xfer_s, pk_full_s, pk_clr_s;
  logic [WORD-1:0] pk_word_s;

  assign xfer_s   = byte_valid_i && byte_ready_o;
  assign pk_clr_s = (state_r != ST_RECV);

  byte_packer #(.WORD(WORD)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (pk_clr_s),
    .push      (xfer_s),
    .data      (byte_data_i),
    .word_next (pk_word_s),
    .full      (pk_full_s)
  );

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!start_i)                next_s = ST_IDLE;
        else if (len_i == '0)        next_s = ST_DONE;
        else if (len_i > MAX_LEN)    next_s = ST_ERR;
        else                         next_s = ST_RECV;
      end
      ST_RECV: begin
        if (pk_full_s)                                 next_s = ST_WRITE;
        else if (!xfer_s && tmo_r == TW'(TIMEOUT - 1)) next_s = ST_ERR;
        else                                           next_s = ST_RECV;
      end
      ST_WRITE: begin
        if (addr_r + (ADDR_W + 1)'(1) == len_r) next_s = ST_DONE;
        else                                    next_s = ST_RECV;
      end
      ST_DONE: next_s = ST_IDLE;
      ST_ERR:  next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs (outputs follow the state being entered).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      len_r        <= '0;
      addr_r       <= '0;
      tmo_r        <= '0;
      byte_ready_o <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr_o   <= '0;
      mem_in       <= '0;
      stall_o      <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_r      <= next_s;
      byte_ready_o <= (next_s == ST_RECV);
      mem_write    <= (next_s == ST_WRITE);
      stall_o      <= (next_s inside {ST_RECV, ST_WRITE, ST_DONE});
      busy_o       <= (next_s != ST_IDLE);
      done_o       <= (next_s == ST_DONE);
      if (next_s == ST_WRITE) begin
        mem_addr_o <= addr_r[ADDR_W-1:0];
        mem_in     <= pk_word_s;
      end
      if (state_r == ST_IDLE && start_i) begin
        len_r  <= len_i;
        addr_r <= '0;
        err_o  <= 1'b0;
      end else if (state_r == ST_WRITE) begin
        addr_r <= addr_r + (ADDR_W + 1)'(1);
      end
      // Error flag is set last so a rejected start still leaves it high.
      if (next_s == ST_ERR) err_o <= 1'b1;
      if (state_r == ST_RECV && next_s == ST_RECV && !xfer_s) tmo_r <= tmo_r + TW'(1);
      else                                                    tmo_r <= '0;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised scoreboard bench for prog_loader.
module tb_prog_loader;

  localparam int WORD    = 32;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 24;

  logic              clk = 1'b0;
  logic              reset, start_i, byte_valid_i;
  logic [ADDR_W:0]   len_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o, mem_write, stall_o, busy_o, done_o, err_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WORD-1:0]   mem_in;

  typedef struct {int addr; logic [WORD-1:0] data;} wr_t;
  wr_t             exp_q[$];
  logic [7:0]      stim[$];
  logic [WORD-1:0] model_mem [256];
  logic [WORD-1:0] dut_mem [256];
  int compared = 0, mismatched = 0, cyc = 0;

  prog_loader #(.WORD(WORD), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .len_i(len_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .mem_write(mem_write), .mem_addr_o(mem_addr_o), .mem_in(mem_in),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every memory write and checks handshake invariants.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      dut_mem[mem_addr_o] <= mem_in;
      chk("stall_covers_write", stall_o, 1);
      chk("ready_low_in_write", byte_ready_o, 0);
      if (exp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", mem_addr_o, mem_in);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", mem_addr_o, w.addr);
        chk("wr_data", mem_in, w.data);
      end
    end
    if (busy_o === 1'b1 && stall_o && !mem_write && !done_o) chk("ready_in_recv", byte_ready_o, 1);
    if (busy_o === 1'b0) chk("ready_low_idle", byte_ready_o, 0);
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int t = 0;
    repeat (gap) @(negedge clk);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (!byte_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = byte_ready_o;
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  // mode 0: complete load, 1: stop sending (timeout), 2: reset after nsend bytes.
  task automatic run_load(input int len, input int nsend, input int max_gap,
                          input int mode, input int exp_cycles);
    int t0, t, gap;
    bit ok, exp_err;
    logic [WORD-1:0] w;
    exp_err = (len > 256) || (mode == 1);
    if (len <= 256)
      for (int k = 0; k < nsend / 4 && k < len; k++) begin
        w = '0;
        for (int j = 0; j < 4; j++) w = w + (WORD'(stim[4*k+j]) << (8*j));
        exp_q.push_back('{k, w});
        model_mem[k] = w;
      end
    start_i = 1'b1;
    len_i   = len[ADDR_W:0];
    t0      = cyc;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    chk("err_on_start", err_o, len > 256);
    if (len <= 256 && len > 0)
      for (int i = 0; i < nsend; i++) begin
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        send_byte(stim[i], gap, ok);
        chk("byte_accepted", ok, 1);
      end
    if (mode == 2) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", busy_o, 0);   chk("rst_stall", stall_o, 0);
      chk("rst_ready", byte_ready_o, 0); chk("rst_write", mem_write, 0);
      chk("rst_done", done_o, 0);   chk("rst_err", err_o, 0);
      chk("rst_addr", mem_addr_o, 0); chk("rst_data", mem_in, 0);
      chk("rst_pending", exp_q.size(), 0);
      exp_q.delete();
      return;
    end
    if (mode == 1) t0 = cyc;
    t = 0;
    while (!done_o && !err_o && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("done", done_o, !exp_err);
    chk("err", err_o, exp_err);
    chk("stall_at_end", stall_o, !exp_err);
    if (exp_cycles > 0) chk("latency", cyc - t0, exp_cycles);
    @(negedge clk);
    chk("done_pulse", done_o, 0);
    chk("idle_after", busy_o, 0);
    chk("err_sticky", err_o, exp_err);
    chk("pending_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  initial begin
    int len;
    reset = 1'b1; start_i = 1'b0; len_i = '0; byte_valid_i = 1'b0; byte_data_i = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy_o, 0);  chk("reset_stall", stall_o, 0);
    chk("reset_done", done_o, 0);  chk("reset_err", err_o, 0);
    chk("reset_write", mem_write, 0); chk("reset_mem_in", mem_in, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: two words back-to-back, 10 cycles in RECV/WRITE then DONE.
    stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(2, 8, 0, 0, 11);
    chk("mem0", dut_mem[0], 32'h12345678);
    chk("mem1", dut_mem[1], 32'hDEADBEEF);

    run_load(0, 0, 0, 0, 1);      // empty load
    run_load(257, 0, 0, 0, 1);    // oversize length rejected
    rand_stim(4);
    run_load(1, 4, 0, 0, 6);      // clears the sticky error

    for (int r = 0; r < 5; r++) begin
      len = int'($urandom_range(6, 1));
      rand_stim(4 * len);
      run_load(len, 4 * len, 20, 0, 0);
    end

    rand_stim(1024);
    run_load(256, 1024, 0, 0, 5 * 256 + 1);   // full memory

    rand_stim(8);
    run_load(2, 6, 3, 1, TIMEOUT);            // stall mid word 1 -> timeout

    rand_stim(32);
    run_load(8, 14, 4, 2, 0);                 // reset during word 3
    for (int k = 0; k < 3; k++) chk("kept_after_reset", dut_mem[k], model_mem[k]);
    rand_stim(4);
    run_load(1, 4, 2, 0, 0);                  // restarts at address 0

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
